// File: rtl/mult_seq.sv
// Sequential 32x32 signed radix-2 Booth multiplier; low 32 product bits, 33-cycle latency.
// Define MULT_OVF_EN to build the signed-overflow flag on data_exception (tied 0 otherwise).

module adder_32 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum,
   output logic        o_overflow
);
   logic [31:0] w_low;
   logic [1:0]  w_high;

   // Overflow is the carry into the sign bit differing from the carry out of it.
   assign w_low      = {1'b0, i_a[30:0]} + {1'b0, i_b[30:0]} + {31'b0, i_cin};
   assign w_high     = {1'b0, i_a[31]} + {1'b0, i_b[31]} + {1'b0, w_low[31]};
   assign o_sum      = {w_high[0], w_low[30:0]};
   assign o_overflow = w_high[1] ^ w_low[31];
endmodule

module mult_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_MULT,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      r_state;
   logic [64:0] r_p;
   logic [31:0] r_m;
   logic [4:0]  r_cnt;
   logic [31:0] r_result;
   logic        r_exception;
   logic        r_rdy;
   logic        r_busy;

   logic [31:0] w_add_b;
   logic        w_cin;
   logic        w_do_add;
   logic [31:0] w_sum;
   logic        w_ovf;
   logic [31:0] w_upper;
   logic        w_sign;
   logic [64:0] w_p_next;
   logic        w_exc;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_add_b  = r_m;
      w_cin    = 1'b0;
      w_do_add = 1'b0;
      case (r_p[1:0])
         2'b01: w_do_add = 1'b1;
         2'b10: begin
            w_do_add = 1'b1;
            w_add_b  = ~r_m;
            w_cin    = 1'b1;
         end
         default: w_do_add = 1'b0;
      endcase
   end

   adder_32 u_adder (
      .i_a        (r_p[64:33]),
      .i_b        (w_add_b),
      .i_cin      (w_cin),
      .o_sum      (w_sum),
      .o_overflow (w_ovf)
   );

   // The shifted-in bit is the true 33-bit sign of the sum, so M = 0x80000000 stays exact.
   assign w_upper  = w_do_add ? w_sum : r_p[64:33];
   assign w_sign   = w_do_add ? (w_sum[31] ^ w_ovf) : r_p[64];
   assign w_p_next = {w_sign, w_upper, r_p[32:1]};

`ifdef MULT_OVF_EN
   assign w_exc = |(w_p_next[64:33] ^ {32{w_p_next[32]}});
`else
   assign w_exc = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_p         <= '0;
         r_m         <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_exception <= 1'b0;
         r_rdy       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ctrl_MULT) begin
                  r_m     <= data_operandA;
                  r_p     <= {32'b0, data_operandB, 1'b0};
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_p   <= w_p_next;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_result    <= w_p_next[32:1];
                  r_exception <= w_exc;
                  r_rdy       <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (ctrl_MULT) begin
                  r_m     <= data_operandA;
                  r_p     <= {32'b0, data_operandB, 1'b0};
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exception;
   assign data_resultRDY = r_rdy;
   assign busy           = r_busy;
endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector bench for mult_seq: latency, handshake, overflow flag, ignored/back-to-back starts, reset abort.

module tb_mult_seq;
   logic        clock;
   logic        reset;
   logic        ctrl_MULT;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MULT_OVF_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   mult_seq dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drives a start sampled at the next rising edge (E0); returns at the falling edge after E0.
   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_MULT     = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'hDEAD_BEEF;
   endtask

   // Counts falling edges after E0 until the ready pulse; optionally injects an extra start mid-run.
   task automatic wait_rdy(input int pulse_at, output int lat, output logic busy_ok);
      lat     = -1;
      busy_ok = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (data_resultRDY) begin
            lat = i;
            if (busy) busy_ok = 1'b0;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if (i == pulse_at) begin
            ctrl_MULT     = 1'b1;
            data_operandA = 32'd9;
            data_operandB = 32'd9;
         end else if (i == pulse_at + 1) begin
            ctrl_MULT = 1'b0;
         end
      end
   endtask

   task automatic finish_check(input string tag, input int pulse_at,
                               input logic [31:0] exp_res, input logic exp_exc, input logic b2b);
      int   lat;
      logic busy_ok;
      wait_rdy(pulse_at, lat, busy_ok);
      check({tag, "_lat"},  lat, 32);
      check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
      check({tag, "_res"},  data_result, exp_res);
      check({tag, "_exc"},  {31'b0, data_exception}, {31'b0, exp_exc});
      if (b2b) begin
         ctrl_MULT     = 1'b1;
         data_operandA = 32'd9;
         data_operandB = 32'd9;
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      check({tag, "_rdy_off"}, {31'b0, data_resultRDY}, 32'd0);
      check({tag, "_hold"},    data_result, exp_res);
      check({tag, "_busy_nx"}, {31'b0, busy}, {31'b0, b2b});
   endtask

   task automatic mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_exc);
      start(a, b);
      check({tag, "_busy0"}, {31'b0, busy}, 32'd1);
      finish_check(tag, 0, exp_res, exp_exc, 1'b0);
   endtask

   initial begin
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (2) @(negedge clock);
      check("rst_res",  data_result, 32'd0);
      check("rst_exc",  {31'b0, data_exception}, 32'd0);
      check("rst_rdy",  {31'b0, data_resultRDY}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;

      mult("m3x4",     32'd3,         32'd4,         32'h0000_000C, 1'b0);
      mult("mneg7x6",  32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 1'b0);
      mult("mmin_x1",  32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
      mult("mmin_xm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, OVF);
      mult("m2p16sq",  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, OVF);
      mult("mm1xm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      mult("mmax_x2",  32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, OVF);

      // Extra start mid-run is ignored; a start in the DONE cycle launches the next multiply.
      start(32'd5, 32'd5);
      finish_check("m5x5", 9, 32'd25, 1'b0, 1'b1);
      finish_check("m9x9", 0, 32'd81, 1'b0, 1'b0);

      // Reset mid-run aborts; a start on the first edge after release is accepted.
      start(32'd100, 32'd100);
      repeat (15) @(negedge clock);
      reset = 1'b1;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      repeat (2) @(negedge clock);
      check("abort_res", data_result, 32'd0);
      check("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
      check("abort_exc", {31'b0, data_exception}, 32'd0);
      reset         = 1'b0;
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd2;
      data_operandB = 32'd3;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      check("post_rst_busy", {31'b0, busy}, 32'd1);
      check("post_rst_res0", data_result, 32'd0);
      finish_check("m2x3", 0, 32'd6, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
